rsa_modexp_scheduler: RTL and testbench

Sequential, shared modular-exponentiation engine computing base^exp mod n by right-to-left square-and-multiply, one exponent bit per clock.

---
 rtl/rsa_modexp_scheduler.sv | 130 +++++++++++++
 tb/tb_rsa_modexp_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_scheduler.sv
// rsa_modexp_scheduler: round-robin shared modexp engine, right-to-left square-and-multiply, one exponent bit per clock
module rsa_modexp_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] base0,
    input  logic [WIDTH-1:0] exp0,
    input  logic [WIDTH-1:0] mod0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] base1,
    input  logic [WIDTH-1:0] exp1,
    input  logic [WIDTH-1:0] mod1,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] base_r, exp_r, acc, n_r;
    logic [WIDTH-1:0] base_n, exp_n, acc_n, n_n, result_n;
    logic [WIDTH-1:0] b_sel, e_sel, m_sel;
    logic [PW-1:0] p_mul, p_sq;
    logic [CW-1:0] cnt, cnt_n;
    logic id, id_n, last, last_n, gnt;
    logic ack0_n, ack1_n, done_n, done_id_n, err_n, busy_n;
    // last holds the requester served most recently; reset to 1 so requester 0 wins first
    always_comb begin
        gnt = (req0 & req1) ? ~last : req1;
        b_sel = gnt ? base1 : base0;
        e_sel = gnt ? exp1 : exp0;
        m_sel = gnt ? mod1 : mod0;
        p_mul = PW'(acc) * PW'(base_r);
        p_sq = PW'(base_r) * PW'(base_r);
        state_n = state;
        base_n = base_r;
        exp_n = exp_r;
        acc_n = acc;
        n_n = n_r;
        cnt_n = cnt;
        id_n = id;
        last_n = last;
        ack0_n = 1'b0;
        ack1_n = 1'b0;
        done_n = 1'b0;
        done_id_n = done_id;
        err_n = err;
        result_n = result;
        case (state)
            IDLE: if (req0 | req1) begin
                ack0_n = ~gnt;
                ack1_n = gnt;
                last_n = gnt;
                id_n = gnt;
                if (m_sel == '0) begin
                    state_n = DONE;
                    done_n = 1'b1;
                    done_id_n = gnt;
                    err_n = 1'b1;
                    result_n = '0;
                end else begin
                    state_n = RUN;
                    base_n = b_sel % m_sel;
                    exp_n = e_sel;
                    acc_n = WIDTH'(1) % m_sel;
                    n_n = m_sel;
                    cnt_n = '0;
                end
            end
            RUN: begin
                acc_n = exp_r[0] ? WIDTH'(p_mul % PW'(n_r)) : acc;
                base_n = WIDTH'(p_sq % PW'(n_r));
                exp_n = exp_r >> 1;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                    done_n = 1'b1;
                    done_id_n = id;
                    err_n = 1'b0;
                    result_n = acc_n;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base_r <= '0;
            exp_r <= '0;
            acc <= '0;
            n_r <= '0;
            cnt <= '0;
            id <= 1'b0;
            last <= 1'b1;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            done_id <= 1'b0;
            err <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            base_r <= base_n;
            exp_r <= exp_n;
            acc <= acc_n;
            n_r <= n_n;
            cnt <= cnt_n;
            id <= id_n;
            last <= last_n;
            ack0 <= ack0_n;
            ack1 <= ack1_n;
            busy <= busy_n;
            done <= done_n;
            done_id <= done_id_n;
            err <= err_n;
            result <= result_n;
        end
    end
endmodule

// File: tb/tb_rsa_modexp_scheduler.sv
// tb_rsa_modexp_scheduler: randomized and directed checks of the shared modexp engine against a loop-based model
module tb_rsa_modexp_scheduler;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] base0 = '0, exp0 = '0, mod0 = '0;
    logic [W-1:0] base1 = '0, exp1 = '0, mod1 = '0;
    logic ack0, ack1, busy, done, done_id, err;
    logic [W-1:0] result;
    int vectors = 0, miscompares = 0;

    rsa_modexp_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .base0(base0), .exp0(exp0), .mod0(mod0), .ack0(ack0),
        .req1(req1), .base1(base1), .exp1(exp1), .mod1(mod1), .ack1(ack1),
        .busy(busy), .done(done), .done_id(done_id), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    // plain repeated multiplication, exp times
    function automatic logic [W-1:0] ref_modexp(input int b, input int e, input int n);
        int r;
        if (n == 0) return '0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return W'(r);
    endfunction

    task automatic set_port(input bit p, input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        if (p) begin base1 = b; exp1 = e; mod1 = n; end
        else begin base0 = b; exp0 = e; mod0 = n; end
    endtask

    task automatic wait_ack(input logic [1:0] mask);
        int t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!((mask[0] & ack0) | (mask[1] & ack1)) && t < 50);
        if (t >= 50) chk("ack_timeout", 0, 1);
    endtask

    // entered at the sample showing ack; leaves at the sample after the return to IDLE
    task automatic finish_op(input bit p, input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        if (n == 0) begin
            chk("z_done", done, 1);
            chk("z_err", err, 1);
            chk("z_result", result, 0);
            chk("z_id", done_id, p);
        end else begin
            chk("ack_no_done", done, 0);
            chk("ack_busy", busy, 1);
            repeat (W - 1) begin
                @(posedge clk); #1;
                chk("run_quiet", {busy, done}, 2'b10);
            end
            @(posedge clk); #1;
            chk("done", done, 1);
            chk("done_id", done_id, p);
            chk("result", result, ref_modexp(b, e, n));
            chk("err", err, 0);
            chk("done_busy", busy, 1);
        end
        @(posedge clk); #1;
        chk("idle", {busy, done}, 0);
    endtask

    task automatic run_op(input bit p, input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        @(negedge clk);
        set_port(p, b, e, n);
        if (p) req1 = 1'b1; else req0 = 1'b1;
        wait_ack(p ? 2'b10 : 2'b01);
        chk("ack_port", {ack1, ack0}, p ? 2'b10 : 2'b01);
        req0 = 1'b0;
        req1 = 1'b0;
        finish_op(p, b, e, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] b, e, n, b0, e0, n0, b1, e1, n1;
        bit p, want;
        int dones;
        do_reset();
        chk("rst_outs", {ack0, ack1, busy, done, done_id, err}, 0);
        chk("rst_result", result, 0);

        run_op(1, 29, 3, 33);
        chk("decrypt_const", result, 2);
        run_op(0, 2, 7, 33);
        chk("encrypt_const", result, 29);
        run_op(1, result, 3, 33);
        chk("round_trip", result, 2);
        run_op(0, 123, 45, 0);
        run_op(1, 5, 3, 1);
        chk("mod1_const", result, 0);
        run_op(0, 7, 0, 33);
        chk("exp0_const", result, 1);
        run_op(1, 200, 255, 251);

        for (int i = 0; i < 30; i++) begin
            p = 1'($urandom);
            b = W'($urandom);
            e = W'($urandom);
            n = ($urandom_range(0, 9) == 0) ? W'(0) : ($urandom_range(0, 9) == 0) ? W'(1) : W'($urandom);
            run_op(p, b, e, n);
        end

        do_reset();
        @(negedge clk);
        b0 = W'($urandom); e0 = W'($urandom); n0 = W'($urandom_range(2, 255));
        b1 = W'($urandom); e1 = W'($urandom); n1 = W'($urandom_range(2, 255));
        set_port(0, b0, e0, n0);
        set_port(1, b1, e1, n1);
        req0 = 1'b1;
        req1 = 1'b1;
        want = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(2'b11);
            chk("rr_grant", {ack1, ack0}, want ? 2'b10 : 2'b01);
            if (want) begin
                req1 = 1'b0;
                finish_op(1, b1, e1, n1);
                req1 = 1'b1;
            end else begin
                req0 = 1'b0;
                finish_op(0, b0, e0, n0);
                req0 = 1'b1;
            end
            want = ~want;
        end
        req0 = 1'b0;
        req1 = 1'b0;

        @(negedge clk);
        set_port(0, 9, 13, 97);
        req0 = 1'b1;
        wait_ack(2'b01);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_outs", {busy, done, ack0, ack1}, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        chk("no_done_after_rst", dones, 0);
        @(negedge clk);
        b0 = W'($urandom); e0 = W'($urandom); n0 = W'($urandom_range(2, 255));
        b1 = W'($urandom); e1 = W'($urandom); n1 = W'($urandom_range(2, 255));
        set_port(0, b0, e0, n0);
        set_port(1, b1, e1, n1);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack(2'b11);
        chk("post_rst_prio", {ack1, ack0}, 2'b01);
        req0 = 1'b0;
        finish_op(0, b0, e0, n0);
        wait_ack(2'b10);
        chk("post_rst_second", {ack1, ack0}, 2'b10);
        req1 = 1'b0;
        finish_op(1, b1, e1, n1);

        @(negedge clk);
        b0 = W'($urandom); e0 = W'($urandom); n0 = W'($urandom_range(2, 255));
        set_port(0, b0, e0, n0);
        req0 = 1'b1;
        wait_ack(2'b01);
        finish_op(0, b0, e0, n0);
        chk("hold_no_early_ack", ack0, 0);
        @(posedge clk); #1;
        chk("hold_reack", ack0, 1);
        req0 = 1'b0;
        finish_op(0, b0, e0, n0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
